bus_addr_map: RTL and testbench

BUS_ADDR_MAP -- requirements
Module: bus_addr_map

---
 rtl/bus_addr_map.sv | 151 +++++++++++++++
 tb/tb_bus_addr_map.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_addr_map.sv
// Address decoder: maps a master address onto one of N_SLV programmable slave regions.
// Latency: one cycle from M_req to the registered S_sel / dec_err result.
// Backpressure: none; a new request is accepted and decoded every cycle.
//
// Ports:
//   clk, reset_n            - single clock, asynchronous active-low reset
//   M_req, M_addr           - master address valid strobe and address
//   S_sel                   - registered one-hot slave select (bit i = slave i)
//   dec_err                 - registered one-cycle decode-miss pulse
//   err_addr, err_cnt       - last missed address, saturating miss count
//   err_clr                 - synchronous clear of err_cnt
//   cfg_we, cfg_idx,
//   cfg_fld, cfg_wdata      - region-table write port (fld 0=base, 1=mask, 2=enable)
module bus_addr_map #(
  parameter int ADDR_W = 8,
  parameter int N_SLV  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M_req,
  input  logic [ADDR_W-1:0] M_addr,
  output logic [N_SLV-1:0]  S_sel,
  output logic              dec_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_clr,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  logic [1:0]        cfg_fld,
  input  logic [ADDR_W-1:0] cfg_wdata
);

  localparam logic [1:0] FLD_BASE = 2'd0;
  localparam logic [1:0] FLD_MASK = 2'd1;
  localparam logic [1:0] FLD_EN   = 2'd2;

  // Reset table values live in the top 8 address bits; lower bits stay zero.
  function automatic logic [ADDR_W-1:0] top8(input logic [7:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    r[ADDR_W-1 -: 8] = v;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rst_base(input int idx);
    case (idx)
      0:       return top8(8'h00);
      1:       return top8(8'h10);
      2:       return top8(8'h20);
      3:       return top8(8'h40);
      default: return '0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rst_mask(input int idx);
    case (idx)
      0, 1:    return top8(8'hF0);
      2, 3:    return top8(8'hE0);
      default: return '0;
    endcase
  endfunction

  // Region table
  logic [ADDR_W-1:0] base_q [N_SLV];
  logic [ADDR_W-1:0] mask_q [N_SLV];
  logic [N_SLV-1:0]  en_q;

  // Decode results
  logic [N_SLV-1:0]  s_sel_q, s_sel_d;
  logic              dec_err_q, dec_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [N_SLV-1:0]  hit_sel;
  logic              hit;
  logic              miss;

  // Table writes. Indices at or above N_SLV never compare equal to a loop
  // index, and the reserved field matches no case, so both drop silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SLV; i++) begin
        base_q[i] <= rst_base(i);
        mask_q[i] <= rst_mask(i);
        en_q[i]   <= (i < 4);
      end
    end else if (cfg_we) begin
      for (int i = 0; i < N_SLV; i++) begin
        if (cfg_idx == 4'(i)) begin
          case (cfg_fld)
            FLD_BASE: base_q[i] <= cfg_wdata;
            FLD_MASK: mask_q[i] <= cfg_wdata;
            FLD_EN:   en_q[i]   <= cfg_wdata[0];
            default:  ;
          endcase
        end
      end
    end
  end

  // Priority match: scan from the top down so the lowest matching index
  // overwrites any higher one, leaving exactly one bit set.
  always_comb begin
    hit_sel = '0;
    hit     = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (en_q[i] && ((M_addr & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  assign miss = M_req && !hit;

  always_comb begin
    s_sel_d    = M_req ? hit_sel : '0;
    dec_err_d  = miss;
    err_addr_d = miss ? M_addr : err_addr_q;
    // A clear coinciding with a miss still counts that miss.
    if (err_clr) begin
      err_cnt_d = miss ? CNT_W'(1) : '0;
    end else if (miss && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_sel_q    <= '0;
      dec_err_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      s_sel_q    <= s_sel_d;
      dec_err_q  <= dec_err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign S_sel    = s_sel_q;
  assign dec_err  = dec_err_q;
  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bus_addr_map.sv
// Testbench for bus_addr_map: scenario tasks with a queue of expected decode results.
// Latency: each driven request is checked one clock after it is presented.
// Backpressure: not applicable; one request per cycle.
module tb_bus_addr_map;

  logic       clk;
  logic       reset_n;
  logic       M_req;
  logic [7:0] M_addr;
  logic [3:0] S_sel;
  logic       dec_err;
  logic [7:0] err_addr;
  logic [7:0] err_cnt;
  logic       err_clr;
  logic       cfg_we;
  logic [3:0] cfg_idx;
  logic [1:0] cfg_fld;
  logic [7:0] cfg_wdata;

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0] sel;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  bus_addr_map #(.ADDR_W(8), .N_SLV(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .M_req     (M_req),
    .M_addr    (M_addr),
    .S_sel     (S_sel),
    .dec_err   (dec_err),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_fld   (cfg_fld),
    .cfg_wdata (cfg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs on the falling edge, then advance past the next rising edge.
  task automatic step(input logic req, input logic [7:0] addr, input logic clr);
    @(negedge clk);
    M_req   = req;
    M_addr  = addr;
    err_clr = clr;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] sel, input logic err, input string name);
    exp_t e;
    e.sel  = sel;
    e.err  = err;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    M_req = 1'b0; M_addr = '0; err_clr = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_fld = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (S_sel !== 4'b0000) $display("FAIL reset_sel got %b want 0000", S_sel); else n_pass++;
    n_total++; if (dec_err !== 1'b0) $display("FAIL reset_err got %b want 0", dec_err); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (err_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", err_addr); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [7:0] addrs [4];
    logic [3:0] sels  [4];
    exp_t e;
    addrs = '{8'h05, 8'h1A, 8'h3F, 8'h55};
    sels  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      push_exp(sels[i], 1'b0, "decode");
      step(1'b1, addrs[i], 1'b0);
      e = exp_q.pop_front();
      n_total++;
      if (S_sel !== e.sel || dec_err !== e.err)
        $display("FAIL %s[%0d] got sel=%b err=%b want sel=%b err=%b", e.name, i, S_sel, dec_err, e.sel, e.err);
      else n_pass++;
    end
    n_total++; if (err_cnt !== 8'd0) $display("FAIL decode_cnt got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_miss();
    exp_t e;
    push_exp(4'b0000, 1'b1, "miss");
    step(1'b1, 8'h80, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
    n_total++; if (err_addr !== 8'h80) $display("FAIL miss_addr got %h want 80", err_addr); else n_pass++;
    n_total++; if (err_cnt !== 8'd1) $display("FAIL miss_cnt got %0d want 1", err_cnt); else n_pass++;
    // Idle cycle with the same address: pulse must drop, counters hold.
    push_exp(4'b0000, 1'b0, "idle");
    step(1'b0, 8'h80, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
    n_total++; if (err_cnt !== 8'd1) $display("FAIL idle_cnt got %0d want 1", err_cnt); else n_pass++;
  endtask

  task automatic test_cfg_write();
    exp_t e;
    // Write region3 base=0x80 while decoding 0x80: decode sees the old table.
    cfg_we = 1'b1; cfg_idx = 4'd3; cfg_fld = 2'd0; cfg_wdata = 8'h80;
    push_exp(4'b0000, 1'b1, "write_cycle");
    step(1'b1, 8'h80, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
    n_total++; if (err_cnt !== 8'd2) $display("FAIL write_cycle_cnt got %0d want 2", err_cnt); else n_pass++;
    push_exp(4'b1000, 1'b0, "after_write");
    step(1'b1, 8'h80, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
    // Reserved field and out-of-range index must not touch region0.
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_fld = 2'd3; cfg_wdata = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    cfg_we = 1'b1; cfg_idx = 4'd4; cfg_fld = 2'd1; cfg_wdata = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    cfg_we = 1'b1; cfg_idx = 4'd8; cfg_fld = 2'd2; cfg_wdata = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    push_exp(4'b0010, 1'b0, "ignored_write");
    step(1'b1, 8'h1A, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
    push_exp(4'b0001, 1'b0, "ignored_write_r0");
    step(1'b1, 8'h05, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
  endtask

  task automatic test_priority();
    logic [7:0] addrs [3];
    logic [3:0] sels  [3];
    exp_t e;
    cfg_we = 1'b1; cfg_idx = 4'd1; cfg_fld = 2'd1; cfg_wdata = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    addrs = '{8'h05, 8'h90, 8'h3F};
    sels  = '{4'b0001, 4'b0010, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      push_exp(sels[i], 1'b0, "priority");
      step(1'b1, addrs[i], 1'b0);
      e = exp_q.pop_front();
      n_total++;
      if (S_sel !== e.sel || dec_err !== e.err)
        $display("FAIL %s[%0d] got sel=%b err=%b want sel=%b err=%b", e.name, i, S_sel, dec_err, e.sel, e.err);
      else n_pass++;
    end
    // Disabling region1 lets region3 (base 0x80) claim 0x90.
    cfg_we = 1'b1; cfg_idx = 4'd1; cfg_fld = 2'd2; cfg_wdata = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    push_exp(4'b1000, 1'b0, "disabled_r1");
    step(1'b1, 8'h90, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
  endtask

  task automatic test_saturate();
    exp_t e;
    int   bad;
    step(1'b0, 8'h00, 1'b1);
    n_total++; if (err_cnt !== 8'd0) $display("FAIL clr_cnt got %0d want 0", err_cnt); else n_pass++;
    // 0x60 misses every enabled region of the current table.
    bad = 0;
    for (int i = 1; i <= 300; i++) begin
      push_exp(4'b0000, 1'b1, "sat_miss");
      step(1'b1, 8'h60, 1'b0);
      e = exp_q.pop_front();
      if (S_sel !== e.sel || dec_err !== e.err) bad++;
      if (i == 254) begin
        n_total++; if (err_cnt !== 8'd254) $display("FAIL cnt_254 got %0d want 254", err_cnt); else n_pass++;
      end
    end
    n_total++; if (bad != 0) $display("FAIL sat_miss_pulses got %0d bad want 0", bad); else n_pass++;
    n_total++; if (err_cnt !== 8'd255) $display("FAIL cnt_sat got %0d want 255", err_cnt); else n_pass++;
    push_exp(4'b0000, 1'b1, "clr_with_miss");
    step(1'b1, 8'h61, 1'b1);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
    n_total++; if (err_cnt !== 8'd1) $display("FAIL clr_miss_cnt got %0d want 1", err_cnt); else n_pass++;
    step(1'b0, 8'h00, 1'b1);
    n_total++; if (err_cnt !== 8'd0) $display("FAIL clr_only_cnt got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (err_addr !== 8'h61) $display("FAIL clr_keeps_addr got %h want 61", err_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    step(1'b1, 8'h60, 1'b0);
    n_total++; if (dec_err !== 1'b1 || err_cnt !== 8'd1)
      $display("FAIL pre_reset got err=%b cnt=%0d want err=1 cnt=1", dec_err, err_cnt); else n_pass++;
    // Second miss presented, then reset pulled low before the edge that would register it.
    @(negedge clk);
    M_req = 1'b1; M_addr = 8'h62;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (S_sel !== 4'b0000 || dec_err !== 1'b0 || err_cnt !== 8'd0 || err_addr !== 8'h00)
      $display("FAIL async_reset got sel=%b err=%b cnt=%0d addr=%h want all zero", S_sel, dec_err, err_cnt, err_addr);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    M_req = 1'b0;
    reset_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    n_total++;
    if (dec_err !== 1'b0 || err_cnt !== 8'd0)
      $display("FAIL post_reset got err=%b cnt=%0d want err=0 cnt=0", dec_err, err_cnt);
    else n_pass++;
    // Table is back to its reset contents: region1 enabled with mask 0xF0.
    push_exp(4'b0010, 1'b0, "table_restored");
    step(1'b1, 8'h1A, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (S_sel !== e.sel || dec_err !== e.err)
      $display("FAIL %s got sel=%b err=%b want sel=%b err=%b", e.name, S_sel, dec_err, e.sel, e.err);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_decode();
    test_miss();
    test_cfg_write();
    test_priority();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
